// File: rtl/dp_decode.sv
// dp_decode: single-issue decode stage for a 32-bit data-processing encoding.
// Takes one instruction through a valid/ready handshake, checks legality and
// the condition field against the APSR flags, then issues it to the execute
// units and waits for completion. A wait limit aborts hung execute units.
//
// Handshake: instr is transferred on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only while the FSM is idle.
// The producer may hold instr_valid high while instr_ready is low. The
// decoder never drops an accepted word except on reset.
module dp_decode #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  input  logic             flag_n,
  input  logic             flag_z,
  input  logic             flag_c,
  input  logic             flag_v,
  output logic [3:0]       rn_addr,
  output logic [3:0]       rm_addr,
  input  logic [31:0]      rn_data,
  input  logic [31:0]      rm_data,
  output logic [15:0]      en_inst,
  output logic             IMM,
  output logic             S,
  output logic [11:0]      imm_operand,
  output logic [4:0]       imm_shift,
  output logic [1:0]       stype,
  output logic [3:0]       rd_addr,
  output logic [31:0]      Rn,
  output logic [31:0]      Rm,
  input  logic             exec_done,
  output logic             illegal,
  output logic             skipped,
  output logic             timeout,
  output logic [CNT_W-1:0] issue_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_ISSUE  = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  // Last WAIT count value; the wait that brings the counter to TIMEOUT is final.
  localparam logic [7:0]       WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic             illegal_q, illegal_d;
  logic             skipped_q, skipped_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       opcode_q, opcode_d;
  logic             imm_q, imm_d;
  logic             s_q, s_d;
  logic [11:0]      imm_operand_q, imm_operand_d;
  logic [4:0]       imm_shift_q, imm_shift_d;
  logic [1:0]       stype_q, stype_d;
  logic [3:0]       rd_addr_q, rd_addr_d;
  logic [31:0]      rn_q, rn_d;
  logic [31:0]      rm_q, rm_d;

  // Field views of the latched word.
  logic [3:0] f_cond;
  logic [1:0] f_class;
  logic       f_i;
  logic       is_illegal;
  logic       cond_pass;

  assign f_cond  = instr_q[31:28];
  assign f_class = instr_q[27:26];
  assign f_i     = instr_q[25];

  // Legality: only class 00, no NV condition, and register-shifted-register
  // (I=0 with bit4 set) is not supported by the execute units.
  assign is_illegal = (f_class != 2'b00) || (f_cond == 4'hF) || (!f_i && instr_q[4]);

  // ARM condition-code evaluation against the live flags.
  always_comb begin
    cond_pass = 1'b0;
    case (f_cond)
      4'h0: cond_pass = flag_z;
      4'h1: cond_pass = !flag_z;
      4'h2: cond_pass = flag_c;
      4'h3: cond_pass = !flag_c;
      4'h4: cond_pass = flag_n;
      4'h5: cond_pass = !flag_n;
      4'h6: cond_pass = flag_v;
      4'h7: cond_pass = !flag_v;
      4'h8: cond_pass = flag_c && !flag_z;
      4'h9: cond_pass = !flag_c || flag_z;
      4'hA: cond_pass = (flag_n == flag_v);
      4'hB: cond_pass = (flag_n != flag_v);
      4'hC: cond_pass = !flag_z && (flag_n == flag_v);
      4'hD: cond_pass = flag_z || (flag_n != flag_v);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Next-state and datapath-capture logic for the decode FSM.
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    wait_cnt_d    = wait_cnt_q;
    issue_cnt_d   = issue_cnt_q;
    illegal_d     = 1'b0;
    skipped_d     = 1'b0;
    timeout_d     = 1'b0;
    opcode_d      = opcode_q;
    imm_d         = imm_q;
    s_d           = s_q;
    imm_operand_d = imm_operand_q;
    imm_shift_d   = imm_shift_q;
    stype_d       = stype_q;
    rd_addr_d     = rd_addr_q;
    rn_d          = rn_q;
    rm_d          = rm_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_illegal) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end else if (!cond_pass) begin
          skipped_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          opcode_d      = instr_q[24:21];
          imm_d         = instr_q[25];
          s_d           = instr_q[20];
          rd_addr_d     = instr_q[15:12];
          imm_operand_d = instr_q[11:0];
          imm_shift_d   = instr_q[11:7];
          stype_d       = instr_q[6:5];
          rn_d          = rn_data;
          rm_d          = rm_data;
          wait_cnt_d    = 8'd0;
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue_cnt_d = issue_cnt_q + CNT_ONE;
        state_d     = exec_done ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (exec_done) begin
          state_d = S_IDLE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and capture registers; reset abandons any pending instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      wait_cnt_q    <= '0;
      issue_cnt_q   <= '0;
      illegal_q     <= 1'b0;
      skipped_q     <= 1'b0;
      timeout_q     <= 1'b0;
      opcode_q      <= '0;
      imm_q         <= 1'b0;
      s_q           <= 1'b0;
      imm_operand_q <= '0;
      imm_shift_q   <= '0;
      stype_q       <= '0;
      rd_addr_q     <= '0;
      rn_q          <= '0;
      rm_q          <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      wait_cnt_q    <= wait_cnt_d;
      issue_cnt_q   <= issue_cnt_d;
      illegal_q     <= illegal_d;
      skipped_q     <= skipped_d;
      timeout_q     <= timeout_d;
      opcode_q      <= opcode_d;
      imm_q         <= imm_d;
      s_q           <= s_d;
      imm_operand_q <= imm_operand_d;
      imm_shift_q   <= imm_shift_d;
      stype_q       <= stype_d;
      rd_addr_q     <= rd_addr_d;
      rn_q          <= rn_d;
      rm_q          <= rm_d;
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign rn_addr     = (state_q == S_DECODE) ? instr_q[19:16] : 4'd0;
  assign rm_addr     = (state_q == S_DECODE) ? instr_q[3:0]   : 4'd0;
  assign en_inst     = (state_q == S_ISSUE) ? (16'd1 << opcode_q) : 16'd0;
  assign IMM         = imm_q;
  assign S           = s_q;
  assign imm_operand = imm_operand_q;
  assign imm_shift   = imm_shift_q;
  assign stype       = stype_q;
  assign rd_addr     = rd_addr_q;
  assign Rn          = rn_q;
  assign Rm          = rm_q;
  assign illegal     = illegal_q;
  assign skipped     = skipped_q;
  assign timeout     = timeout_q;
  assign issue_cnt   = issue_cnt_q;

endmodule

// File: tb/tb_dp_decode.sv
// Bench for dp_decode: directed scenarios plus randomized instructions checked
// against an outcome model built from the instruction-set rules.
module tb_dp_decode;

  localparam int TMO = 4;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic [31:0]   instr = '0;
  logic          instr_ready;
  logic          flag_n = 1'b0, flag_z = 1'b0, flag_c = 1'b0, flag_v = 1'b0;
  logic [3:0]    rn_addr, rm_addr;
  logic [31:0]   rn_data, rm_data;
  logic [15:0]   en_inst;
  logic          IMM, S;
  logic [11:0]   imm_operand;
  logic [4:0]    imm_shift;
  logic [1:0]    stype;
  logic [3:0]    rd_addr;
  logic [31:0]   Rn, Rm;
  logic          exec_done = 1'b0;
  logic          illegal, skipped, timeout;
  logic [CW-1:0] issue_cnt;

  logic [31:0] rf [16];
  assign rn_data = rf[rn_addr];
  assign rm_data = rf[rm_addr];

  dp_decode #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v),
    .rn_addr(rn_addr), .rm_addr(rm_addr), .rn_data(rn_data), .rm_data(rm_data),
    .en_inst(en_inst), .IMM(IMM), .S(S), .imm_operand(imm_operand), .imm_shift(imm_shift),
    .stype(stype), .rd_addr(rd_addr), .Rn(Rn), .Rm(Rm), .exec_done(exec_done),
    .illegal(illegal), .skipped(skipped), .timeout(timeout), .issue_cnt(issue_cnt)
  );

  // Clock
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_issued = 0;

  // Observations from the most recent run_instr call.
  logic        o_ready0;
  logic [3:0]  o_rn_addr, o_rm_addr, o_rd;
  logic [15:0] o_en;
  logic        o_imm, o_s;
  logic [11:0] o_imm_op;
  logic [4:0]  o_shift;
  logic [1:0]  o_stype;
  logic [31:0] o_rn, o_rm;
  int o_ill, o_skp, o_tmo, o_ill_cyc, o_skp_cyc, o_tmo_cyc, o_idle_cyc, o_stray;

  // Reference model: ARM condition evaluation, nzcv = {N,Z,C,V}.
  function automatic logic cond_ok(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0: return z;            4'h1: return !z;
      4'h2: return c;            4'h3: return !c;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return c && !z;      4'h9: return !c || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      default: return 1'b1;
    endcase
  endfunction

  // 0 = illegal, 1 = condition failed, 2 = issued
  function automatic int exp_kind(input logic [31:0] ins, input logic [3:0] nzcv);
    if (ins[27:26] != 2'b00 || ins[31:28] == 4'hF || (!ins[25] && ins[4])) return 0;
    if (!cond_ok(ins[31:28], nzcv)) return 1;
    return 2;
  endfunction

  // Cycle after the handshake in which the decoder is back in IDLE for an issued instruction.
  function automatic int exp_idle(input int done_at);
    if (done_at == 0) return 3;
    if (done_at <= TMO) return 3 + done_at;
    return 3 + TMO;
  endfunction

  // Driver/monitor: hand over one instruction and follow it until IDLE.
  // done_at: 0 = exec_done in ISSUE, k = in the k-th WAIT cycle, > TMO = never.
  task automatic run_instr(input logic [31:0] ins, input logic [3:0] nzcv, input int done_at);
    @(negedge clk);
    o_ready0 = instr_ready;
    o_ill = 0; o_skp = 0; o_tmo = 0; o_stray = 0;
    o_ill_cyc = -1; o_skp_cyc = -1; o_tmo_cyc = -1; o_idle_cyc = -1;
    {flag_n, flag_z, flag_c, flag_v} = nzcv;
    instr = ins; instr_valid = 1'b1;
    exec_done = 1'($urandom_range(0, 1));
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        instr_valid = 1'b0; instr = $urandom;
        o_rn_addr = rn_addr; o_rm_addr = rm_addr;
      end
      if (cyc == 2) begin
        o_en = en_inst; o_imm = IMM; o_s = S; o_imm_op = imm_operand; o_shift = imm_shift;
        o_stype = stype; o_rd = rd_addr; o_rn = Rn; o_rm = Rm;
      end else if (en_inst != 16'd0) o_stray++;
      if (illegal) begin o_ill++; o_ill_cyc = cyc; end
      if (skipped) begin o_skp++; o_skp_cyc = cyc; end
      if (timeout) begin o_tmo++; o_tmo_cyc = cyc; end
      if (cyc >= 2 && instr_ready) begin
        o_idle_cyc = cyc;
        exec_done = 1'($urandom_range(0, 1));
        break;
      end
      exec_done = (cyc == 1) ? 1'($urandom_range(0, 1)) : 1'(cyc - 2 == done_at);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; instr_valid = 1'b0; exec_done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_issued = 0;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_checks++; if (instr_ready !== 1'b1) $display("FAIL reset_ready got=%b exp=1", instr_ready); else n_pass++;
    n_checks++;
    if ({en_inst, illegal, skipped, timeout, issue_cnt, rn_addr, rm_addr} !== '0)
      $display("FAIL reset_ctrl got en=%h ill=%b skp=%b tmo=%b cnt=%0d exp all zero",
               en_inst, illegal, skipped, timeout, issue_cnt);
    else n_pass++;
    n_checks++;
    if ({IMM, S, imm_operand, imm_shift, stype, rd_addr, Rn, Rm} !== '0)
      $display("FAIL reset_operands got imm=%h rd=%h rn=%h rm=%h exp zero", imm_operand, rd_addr, Rn, Rm);
    else n_pass++;
  endtask

  task automatic test_immediate_issue();
    run_instr(32'hE3B010FF, 4'b0000, 0);
    exp_issued++;
    n_checks++; if (o_en !== 16'h2000) $display("FAIL imm_en got=%h exp=2000", o_en); else n_pass++;
    n_checks++; if ({o_imm, o_s} !== 2'b11) $display("FAIL imm_flags got=%b%b exp=11", o_imm, o_s); else n_pass++;
    n_checks++; if (o_rd !== 4'd1) $display("FAIL imm_rd got=%0d exp=1", o_rd); else n_pass++;
    n_checks++; if (o_imm_op !== 12'h0FF) $display("FAIL imm_operand got=%h exp=0ff", o_imm_op); else n_pass++;
    n_checks++; if (o_idle_cyc != 3) $display("FAIL imm_idle_cycle got=%0d exp=3", o_idle_cyc); else n_pass++;
    n_checks++; if (o_stray != 0) $display("FAIL imm_stray_en got=%0d exp=0", o_stray); else n_pass++;
    n_checks++; if (issue_cnt !== exp_issued[CW-1:0]) $display("FAIL imm_cnt got=%0d exp=%0d", issue_cnt, exp_issued[CW-1:0]); else n_pass++;
  endtask

  task automatic test_register_form();
    rf[3] = 32'h0000_00F0;
    run_instr(32'hE1A02203, 4'b0000, 0);
    exp_issued++;
    n_checks++; if (o_rm_addr !== 4'd3) $display("FAIL reg_rm_addr got=%0d exp=3", o_rm_addr); else n_pass++;
    n_checks++; if (o_rm !== 32'h0000_00F0) $display("FAIL reg_rm got=%h exp=000000f0", o_rm); else n_pass++;
    n_checks++; if (o_rn !== rf[0]) $display("FAIL reg_rn got=%h exp=%h", o_rn, rf[0]); else n_pass++;
    n_checks++;
    if ({o_imm, o_shift, o_stype, o_rd} !== {1'b0, 5'd4, 2'b00, 4'd2})
      $display("FAIL reg_fields got imm=%b sh=%0d st=%0d rd=%0d exp 0/4/0/2", o_imm, o_shift, o_stype, o_rd);
    else n_pass++;
    n_checks++; if (o_en !== 16'h2000) $display("FAIL reg_en got=%h exp=2000", o_en); else n_pass++;
  endtask

  task automatic test_condition();
    run_instr(32'h03B010FF, 4'b0000, 0);
    n_checks++; if (o_skp != 1 || o_skp_cyc != 2) $display("FAIL cond_skip got n=%0d cyc=%0d exp 1@2", o_skp, o_skp_cyc); else n_pass++;
    n_checks++; if (o_en !== 16'd0 || o_stray != 0) $display("FAIL cond_skip_en got=%h stray=%0d exp 0", o_en, o_stray); else n_pass++;
    n_checks++; if (o_rd !== 4'd2) $display("FAIL cond_hold_rd got=%0d exp=2", o_rd); else n_pass++;
    n_checks++; if (issue_cnt !== exp_issued[CW-1:0]) $display("FAIL cond_skip_cnt got=%0d exp=%0d", issue_cnt, exp_issued[CW-1:0]); else n_pass++;
    run_instr(32'h03B010FF, 4'b0100, 0);
    exp_issued++;
    n_checks++; if (o_en !== 16'h2000 || o_skp != 0) $display("FAIL cond_pass got en=%h skp=%0d exp 2000/0", o_en, o_skp); else n_pass++;
  endtask

  task automatic test_illegal();
    logic [31:0] bad [2];
    bad[0] = 32'hE1A02213;
    bad[1] = 32'hE7A02203;
    for (int i = 0; i < 2; i++) begin
      run_instr(bad[i], 4'b0000, 0);
      n_checks++; if (o_ill != 1 || o_ill_cyc != 2) $display("FAIL illegal_pulse_%0d got n=%0d cyc=%0d exp 1@2", i, o_ill, o_ill_cyc); else n_pass++;
      n_checks++; if (o_en !== 16'd0 || o_stray != 0) $display("FAIL illegal_en_%0d got=%h exp=0", i, o_en); else n_pass++;
      n_checks++; if (issue_cnt !== exp_issued[CW-1:0]) $display("FAIL illegal_cnt_%0d got=%0d exp=%0d", i, issue_cnt, exp_issued[CW-1:0]); else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int done_tab [3];
    done_tab[0] = 255; done_tab[1] = TMO; done_tab[2] = 2;
    for (int i = 0; i < 3; i++) begin
      run_instr(32'hE3B010FF, 4'b0000, done_tab[i]);
      exp_issued++;
      n_checks++;
      if (o_idle_cyc != exp_idle(done_tab[i])) $display("FAIL tmo_idle_%0d got=%0d exp=%0d", i, o_idle_cyc, exp_idle(done_tab[i])); else n_pass++;
      n_checks++;
      if (o_tmo != ((done_tab[i] > TMO) ? 1 : 0)) $display("FAIL tmo_pulse_%0d got=%0d exp=%0d", i, o_tmo, (done_tab[i] > TMO) ? 1 : 0); else n_pass++;
      if (done_tab[i] > TMO) begin
        n_checks++; if (o_tmo_cyc != 3 + TMO) $display("FAIL tmo_cycle got=%0d exp=%0d", o_tmo_cyc, 3 + TMO); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      logic [31:0] ins;
      logic [3:0]  nzcv;
      int          done_at, kind;
      ins = $urandom;
      if ($urandom_range(0, 3) != 0) ins[27:26] = 2'b00;
      nzcv = 4'($urandom_range(0, 15));
      done_at = $urandom_range(0, TMO + 2);
      kind = exp_kind(ins, nzcv);
      run_instr(ins, nzcv, done_at);
      if (kind == 2) exp_issued++;
      n_checks++; if (o_ready0 !== 1'b1) $display("FAIL rnd_ready_%0d got=%b exp=1", k, o_ready0); else n_pass++;
      n_checks++;
      if (o_rn_addr !== ins[19:16] || o_rm_addr !== ins[3:0])
        $display("FAIL rnd_addr_%0d got=%h/%h exp=%h/%h", k, o_rn_addr, o_rm_addr, ins[19:16], ins[3:0]);
      else n_pass++;
      n_checks++;
      if (o_ill != (kind == 0 ? 1 : 0) || o_skp != (kind == 1 ? 1 : 0))
        $display("FAIL rnd_status_%0d ins=%h got ill=%0d skp=%0d exp kind=%0d", k, ins, o_ill, o_skp, kind);
      else n_pass++;
      n_checks++;
      if (o_en !== (kind == 2 ? (16'd1 << ins[24:21]) : 16'd0) || o_stray != 0)
        $display("FAIL rnd_en_%0d ins=%h got=%h stray=%0d", k, ins, o_en, o_stray);
      else n_pass++;
      n_checks++;
      if (o_idle_cyc != (kind == 2 ? exp_idle(done_at) : 2))
        $display("FAIL rnd_idle_%0d got=%0d kind=%0d done_at=%0d", k, o_idle_cyc, kind, done_at);
      else n_pass++;
      n_checks++;
      if (o_tmo != ((kind == 2 && done_at > TMO) ? 1 : 0)) $display("FAIL rnd_tmo_%0d got=%0d done_at=%0d", k, o_tmo, done_at); else n_pass++;
      if (kind == 2) begin
        n_checks++;
        if ({o_imm, o_s, o_rd, o_imm_op, o_shift, o_stype} !== {ins[25], ins[20], ins[15:12], ins[11:0], ins[11:7], ins[6:5]}
            || o_rn !== rf[ins[19:16]] || o_rm !== rf[ins[3:0]])
          $display("FAIL rnd_fields_%0d ins=%h got rd=%h op=%h rn=%h rm=%h", k, ins, o_rd, o_imm_op, o_rn, o_rm);
        else n_pass++;
      end
      n_checks++; if (issue_cnt !== exp_issued[CW-1:0]) $display("FAIL rnd_cnt_%0d got=%0d exp=%0d", k, issue_cnt, exp_issued[CW-1:0]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_wait();
    int tmo_seen;
    @(negedge clk);
    instr = 32'hE3B010FF; instr_valid = 1'b1; exec_done = 1'b0;
    @(negedge clk); instr_valid = 1'b0;   // DECODE
    @(negedge clk);                        // ISSUE
    @(negedge clk);                        // WAIT
    @(negedge clk);                        // WAIT
    #2 rst = 1'b1;
    #1;
    n_checks++; if (instr_ready !== 1'b1) $display("FAIL midrst_ready got=%b exp=1", instr_ready); else n_pass++;
    n_checks++;
    if ({en_inst, timeout, issue_cnt, IMM, S, imm_operand, rd_addr} !== '0)
      $display("FAIL midrst_outputs got en=%h tmo=%b cnt=%0d imm=%h", en_inst, timeout, issue_cnt, imm_operand);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    exp_issued = 0;
    tmo_seen = 0;
    for (int i = 0; i < TMO + 4; i++) begin
      @(negedge clk);
      if (timeout || en_inst != 16'd0) tmo_seen++;
    end
    n_checks++; if (tmo_seen != 0) $display("FAIL midrst_abandon got=%0d exp=0", tmo_seen); else n_pass++;
  endtask

  task automatic test_back_to_back_wrap();
    for (int i = 0; i < 5; i++) begin
      run_instr(32'hE3B010FF, 4'b0000, 0);
      exp_issued++;
    end
    n_checks++; if (issue_cnt !== 2'd1) $display("FAIL wrap_cnt got=%0d exp=1", issue_cnt); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    test_reset();
    test_immediate_issue();
    test_register_form();
    test_condition();
    test_illegal();
    test_timeout();
    test_random();
    test_reset_mid_wait();
    test_back_to_back_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL time_limit got=expired exp=completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/dp_decode.md
DP_DECODE -- requirements
Module: dp_decode

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles in WAIT before abort, legal range 1-255.
REQ-002 Parameter CNT_W, default 16: width of the issued-instruction counter.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset; asynchronous, active-high.
REQ-005 instr_valid  in  1 / instr  in  32 / instr_ready  out  1: instruction handshake; transfer when valid&ready at a rising edge.
REQ-006 flag_n, flag_z, flag_c, flag_v  in  1 each: current APSR flags for condition evaluation.
REQ-007 rn_addr, rm_addr  out  4: register-file read addresses; rn_data, rm_data  in  32: combinational read data.
REQ-008 en_inst  out  16: one-hot execute enable, bit index = opcode[24:21].
REQ-009 IMM, S  out  1; imm_operand  out  12; imm_shift  out  5; stype  out  2; rd_addr  out  4; Rn, Rm  out  32: decoded operands to execute units.
REQ-010 exec_done  in  1: execute-unit completion.
REQ-011 illegal, skipped, timeout  out  1 each: one-cycle status pulses.
REQ-012 issue_cnt  out  CNT_W: count of instructions issued.

Function
REQ-013 Field map: cond=[31:28], class=[27:26], I=[25], opcode=[24:21], S=[20], Rn=[19:16], Rd=[15:12], op2=[11:0]; register form: imm_shift=[11:7], stype=[6:5], Rm=[3:0].
REQ-014 States: IDLE, DECODE, ISSUE, WAIT; instr_ready=1 only in IDLE.
REQ-015 IDLE: on handshake, latch instr into an internal register and go to DECODE; otherwise stay.
REQ-016 DECODE (one cycle): drive rn_addr/rm_addr from the latched word; evaluate illegal and condition.
REQ-017 Illegal: class!=00, cond=1111, or I=0 with bit4=1 -> pulse illegal in the cycle after DECODE, go IDLE, no en_inst.
REQ-018 Condition codes 0000-1110 per ARM semantics (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE,AL); fail -> pulse skipped in the cycle after DECODE, go IDLE, no en_inst.
REQ-019 Pass: at the DECODE->ISSUE edge, capture Rn, Rm, IMM, S, rd_addr, imm_operand=op2, imm_shift, stype; these hold until the next capture.
REQ-020 ISSUE (one cycle): en_inst one-hot high; issue_cnt increments by 1, wrapping at 2^CNT_W-1 -> 0.
REQ-021 exec_done sampled in ISSUE and WAIT; high -> IDLE next cycle; low in ISSUE -> WAIT.
REQ-022 en_inst is zero in every state other than ISSUE.
REQ-023 WAIT: 8-bit counter, cleared on ISSUE entry, increments each WAIT cycle; at count = TIMEOUT with exec_done low, pulse timeout and go IDLE.
REQ-024 exec_done high on the same cycle the counter reaches TIMEOUT: completion wins, no timeout pulse.
REQ-025 Latency: handshake at edge T -> DECODE in cycle T+1 -> en_inst high in cycle T+2; status pulses appear in cycle T+2 instead.
REQ-026 exec_done asserted in IDLE or DECODE is ignored.

Reset
REQ-027 rst asserted: state=IDLE, instr_ready=1 after deassertion, all other outputs 0, issue_cnt=0, WAIT counter=0, latched instruction=0; applies mid-operation without completing the pending instruction.

Verification
REQ-028 instr=0xE3B010FF, exec_done=1 in ISSUE -> en_inst=0x2000, IMM=1, S=1, rd_addr=1, imm_operand=0x0FF, issue_cnt 0->1, back to IDLE at T+3.
REQ-029 instr=0xE1A02203, rm_data=0x0000_00F0 -> IMM=0, imm_shift=4, stype=00, rm_addr=3, Rm=0x000000F0, rd_addr=2, en_inst=0x2000.
REQ-030 instr=0x03B010FF with flag_z=0 -> skipped pulse at T+2, en_inst stays 0; same with flag_z=1 -> issued.
REQ-031 instr=0xE1A02213 and instr=0xE7A02203 -> illegal pulse each, no issue, issue_cnt unchanged.
REQ-032 TIMEOUT=4, exec_done held 0 -> timeout pulse after 4 WAIT cycles, IDLE next; repeat with exec_done=1 on that cycle -> no timeout.
REQ-033 rst asserted during WAIT -> immediate IDLE, outputs 0, issue_cnt=0; CNT_W=2 with 5 issues -> issue_cnt=1.
